// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: format codes, field positions and helpers shared by the immediate generator.
package imm_gen_pkg;
    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_D, FMT_B, FMT_CB, FMT_IW, FMT_RSV6, FMT_RSV7
    } fmt_e;

    // Extension mode also encodes the sign-bit position of the raw field.
    typedef enum logic [1:0] {EXT_ZERO, EXT_S9, EXT_S19, EXT_S26} ext_e;

    localparam int RAW_W     = 26;
    localparam int SHAMT_W   = 6;
    localparam int I_LSB     = 10;
    localparam int I_MSB     = 21;
    localparam int D_LSB     = 12;
    localparam int D_MSB     = 20;
    localparam int B_LSB     = 0;
    localparam int B_MSB     = 25;
    localparam int CB_LSB    = 5;
    localparam int CB_MSB    = 23;
    localparam int IW_LSB    = 5;
    localparam int IW_MSB    = 20;
    localparam int IW_HW_LSB = 21;
    localparam int IW_HW_MSB = 22;
    localparam int IW_STEP   = 16;
    localparam int BR_SHIFT  = 2;

    function automatic logic [RAW_W-1:0] field(input logic [31:0] ins, input int msb, input int lsb);
        return RAW_W'((ins >> lsb) & ~(32'hFFFF_FFFF << (msb - lsb + 1)));
    endfunction
endpackage

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: one-entry valid/ready pipeline register with flush.
module imm_gen_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= !flush & (o_ready ? i_valid : r_valid);
            if (!flush & o_ready & i_valid) r_data <= i_data;
        end
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage LEGv8 immediate generator; S1 holds the extracted field,
// S2 holds the extended and shifted immediate.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [2:0]        fmt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);
    localparam int S1_W = RAW_W + 2 + SHAMT_W + 1 + TAG_W;
    localparam int S2_W = DATA_W + 1 + TAG_W;

    logic [RAW_W-1:0]   w_raw;
    ext_e               w_mode;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_err;
    logic [1:0]         w_hw;
    logic               w_iw_bad;
    logic               w_s1_valid;
    logic               w_s2_ready;
    logic [S1_W-1:0]    w_s1_data;
    logic [RAW_W-1:0]   w_s1_raw;
    logic [1:0]         w_s1_mode;
    logic [SHAMT_W-1:0] w_s1_shamt;
    logic               w_s1_err;
    logic [TAG_W-1:0]   w_s1_tag;
    logic [DATA_W-1:0]  w_ext;
    logic [DATA_W-1:0]  w_imm;
    logic [S2_W-1:0]    w_s2_data;

    assign w_hw     = instr[IW_HW_MSB:IW_HW_LSB];
    assign w_iw_bad = (32'(w_hw) + 32'd1) * IW_STEP > DATA_W;

    always_comb begin
        w_raw   = '0;
        w_mode  = EXT_ZERO;
        w_shamt = '0;
        w_err   = 1'b0;
        case (fmt_e'(fmt))
            FMT_NONE: ;
            FMT_I:    w_raw = field(instr, I_MSB, I_LSB);
            FMT_D: begin
                w_raw  = field(instr, D_MSB, D_LSB);
                w_mode = EXT_S9;
            end
            FMT_B: begin
                w_raw   = field(instr, B_MSB, B_LSB);
                w_mode  = EXT_S26;
                w_shamt = SHAMT_W'(BR_SHIFT);
            end
            FMT_CB: begin
                w_raw   = field(instr, CB_MSB, CB_LSB);
                w_mode  = EXT_S19;
                w_shamt = SHAMT_W'(BR_SHIFT);
            end
            FMT_IW: begin
                w_err   = w_iw_bad;
                w_raw   = w_iw_bad ? '0 : field(instr, IW_MSB, IW_LSB);
                w_shamt = w_iw_bad ? '0 : SHAMT_W'(32'(w_hw) * IW_STEP);
            end
            FMT_RSV6, FMT_RSV7: w_err = 1'b1;
        endcase
    end

    imm_gen_stage #(.W(S1_W)) u_s1 (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({w_raw, w_mode, w_shamt, w_err, in_tag}),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_data)
    );

    assign {w_s1_raw, w_s1_mode, w_s1_shamt, w_s1_err, w_s1_tag} = w_s1_data;

    // Shift happens at full output width so bits past the MSB simply fall off.
    assign w_ext = (w_s1_mode == EXT_S9)  ? {{(DATA_W-9){w_s1_raw[8]}}, w_s1_raw[8:0]} :
                   (w_s1_mode == EXT_S19) ? {{(DATA_W-19){w_s1_raw[18]}}, w_s1_raw[18:0]} :
                   (w_s1_mode == EXT_S26) ? {{(DATA_W-26){w_s1_raw[25]}}, w_s1_raw} :
                                            {{(DATA_W-RAW_W){1'b0}}, w_s1_raw};
    assign w_imm = w_s1_err ? '0 : w_ext << w_s1_shamt;

    imm_gen_stage #(.W(S2_W)) u_s2 (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  ({w_imm, w_s1_err, w_s1_tag}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_data)
    );

    assign {imm, out_err, out_tag} = w_s2_data;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed stimulus against a queue-based reference model plus literal checks.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, in_ready32;
    logic [31:0] instr = '0;
    logic [2:0]  fmt = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid, out_valid32;
    logic        out_ready = 1'b1;
    logic [63:0] imm;
    logic [31:0] imm32;
    logic [3:0]  out_tag, out_tag32;
    logic        out_err, out_err32;

    int n_pass = 0;
    int n_total = 0;

    typedef struct packed {
        logic [63:0] imm;
        logic [3:0]  tag;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.DATA_W(64), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .fmt(fmt), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .out_tag(out_tag), .out_err(out_err)
    );

    imm_gen_pipe #(.DATA_W(32), .TAG_W(4)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .fmt(fmt), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    endtask

    // Reference: plain signed/unsigned arithmetic on the field values.
    function automatic exp_t model(input logic [31:0] ins, input logic [2:0] f, input logic [3:0] t);
        exp_t   e;
        longint s;
        int     hw;
        e = '{imm: 64'd0, tag: t, err: 1'b0};
        case (f)
            3'd1: e.imm = 64'(ins[21:10]);
            3'd2: begin s = $signed(ins[20:12]); e.imm = s; end
            3'd3: begin s = $signed(ins[25:0]); e.imm = s * 4; end
            3'd4: begin s = $signed(ins[23:5]); e.imm = s * 4; end
            3'd5: begin
                hw = int'(ins[22:21]);
                if (16 * hw + 16 > 64) e.err = 1'b1;
                else e.imm = 64'(ins[20:5]) * (64'd1 << (16 * hw));
            end
            3'd6, 3'd7: e.err = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) exp_q.delete();
        else begin
            chk("in_ready_model", in_ready, !(exp_q.size() == 2 && !out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) chk("stale_out_valid", out_valid, 1'b0);
                else begin
                    chk("model_imm", imm, exp_q[0].imm);
                    chk("model_tag", out_tag, exp_q[0].tag);
                    chk("model_err", out_err, exp_q[0].err);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(model(instr, fmt, in_tag));
        end
    end

    function automatic logic [31:0] mk_i(input logic [11:0] v); return {10'd0, v, 10'd0}; endfunction
    function automatic logic [31:0] mk_d(input logic [8:0] v); return {11'd0, v, 12'd0}; endfunction
    function automatic logic [31:0] mk_b(input logic [25:0] v); return {6'd0, v}; endfunction
    function automatic logic [31:0] mk_cb(input logic [18:0] v); return {8'd0, v, 5'd0}; endfunction
    function automatic logic [31:0] mk_iw(input logic [1:0] hw, input logic [15:0] v);
        return {9'd0, hw, v, 5'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [2:0] f, input logic [3:0] t);
        in_valid = 1'b1;
        instr    = ins;
        fmt      = f;
        in_tag   = t;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic run_lit(input string name, input logic [31:0] ins, input logic [2:0] f,
                           input logic [3:0] t, input logic [63:0] e64, input logic err64,
                           input logic [31:0] e32, input logic err32);
        drive(ins, f, t);
        tick();
        idle();
        chk({name, "_lat1_valid"}, out_valid, 1'b0);
        tick();
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_imm"}, imm, e64);
        chk({name, "_tag"}, out_tag, t);
        chk({name, "_err"}, out_err, err64);
        chk({name, "_valid32"}, out_valid32, 1'b1);
        chk({name, "_imm32"}, imm32, e32);
        chk({name, "_err32"}, out_err32, err32);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_imm", imm, 64'd0);
        chk("rst_tag", out_tag, 4'd0);
        chk("rst_err", out_err, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);

        run_lit("b_neg1", mk_b(26'h3FF_FFFF), 3'd3, 4'd5, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0);

        drive(mk_cb(19'h00001), 3'd4, 4'd1);
        tick();
        drive(mk_d(9'h100), 3'd2, 4'd2);
        tick();
        chk("str_cb_imm", imm, 64'd4);
        chk("str_cb_tag", out_tag, 4'd1);
        drive(mk_i(12'hFFF), 3'd1, 4'd3);
        tick();
        chk("str_d_imm", imm, 64'hFFFF_FFFF_FFFF_FF00);
        chk("str_d_tag", out_tag, 4'd2);
        drive(mk_iw(2'd2, 16'hBEEF), 3'd5, 4'd4);
        tick();
        chk("str_i_imm", imm, 64'h0000_0000_0000_0FFF);
        chk("str_i_tag", out_tag, 4'd3);
        idle();
        tick();
        chk("str_iw_valid", out_valid, 1'b1);
        chk("str_iw_imm", imm, 64'h0000_BEEF_0000_0000);
        chk("str_iw_tag", out_tag, 4'd4);
        tick();
        chk("str_drained", out_valid, 1'b0);

        out_ready = 1'b0;
        drive(mk_i(12'h001), 3'd1, 4'd8);
        tick();
        chk("bp_in_ready_1", in_ready, 1'b1);
        drive(mk_i(12'h002), 3'd1, 4'd9);
        tick();
        chk("bp_full_in_ready", in_ready, 1'b0);
        drive(mk_i(12'h003), 3'd1, 4'd10);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bp_hold_in_ready", in_ready, 1'b0);
            chk("bp_hold_imm", imm, 64'd1);
            chk("bp_hold_tag", out_tag, 4'd8);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1'b1);
        tick();
        idle();
        chk("bp_second_tag", out_tag, 4'd9);
        chk("bp_second_imm", imm, 64'd2);
        tick();
        chk("bp_third_tag", out_tag, 4'd10);
        chk("bp_third_imm", imm, 64'd3);
        tick();
        chk("bp_drained", out_valid, 1'b0);

        out_ready = 1'b0;
        drive(mk_i(12'h011), 3'd1, 4'd1);
        tick();
        drive(mk_i(12'h022), 3'd1, 4'd2);
        tick();
        chk("fl_full", in_ready, 1'b0);
        drive(mk_i(12'h033), 3'd1, 4'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        drive(mk_i(12'h044), 3'd1, 4'd11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_drop_accepted", out_valid, 1'b0);
        drive(mk_d(9'h0FF), 3'd2, 4'd4);
        tick();
        idle();
        chk("fl_after_lat1", out_valid, 1'b0);
        tick();
        chk("fl_after_valid", out_valid, 1'b1);
        chk("fl_after_imm", imm, 64'h0000_0000_0000_00FF);
        chk("fl_after_tag", out_tag, 4'd4);
        tick();
        chk("fl_after_drained", out_valid, 1'b0);

        run_lit("rsv6", 32'hFFFF_FFFF, 3'd6, 4'd6, 64'd0, 1'b1, 32'd0, 1'b1);
        run_lit("rsv7", 32'h1234_5678, 3'd7, 4'd7, 64'd0, 1'b1, 32'd0, 1'b1);
        run_lit("none", 32'hFFFF_FFFF, 3'd0, 4'd0, 64'd0, 1'b0, 32'd0, 1'b0);
        run_lit("iw_hw3", mk_iw(2'd3, 16'h1234), 3'd5, 4'd12, 64'h1234_0000_0000_0000, 1'b0, 32'd0, 1'b1);
        run_lit("iw_hw2", mk_iw(2'd2, 16'h00A5), 3'd5, 4'd13, 64'h0000_00A5_0000_0000, 1'b0, 32'd0, 1'b1);
        run_lit("iw_hw1", mk_iw(2'd1, 16'hBEEF), 3'd5, 4'd14, 64'h0000_0000_BEEF_0000, 1'b0, 32'hBEEF_0000, 1'b0);
        run_lit("b_min", mk_b(26'h200_0000), 3'd3, 4'd15, 64'hFFFF_FFFF_F800_0000, 1'b0, 32'hF800_0000, 1'b0);
        run_lit("cb_neg", mk_cb(19'h7FFFF), 3'd4, 4'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0);
        run_lit("i_mid", mk_i(12'h800), 3'd1, 4'd2, 64'h0000_0000_0000_0800, 1'b0, 32'h0000_0800, 1'b0);

        drive(mk_i(12'h001), 3'd1, 4'd7);
        tick();
        drive(mk_i(12'h002), 3'd1, 4'd8);
        tick();
        chk("ar_pre_valid", out_valid, 1'b1);
        #2;
        reset = 1'b1;
        idle();
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_in_ready", in_ready, 1'b1);
        chk("ar_imm", imm, 64'd0);
        chk("ar_tag", out_tag, 4'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_no_stale", out_valid, 1'b0);
            chk("ar_ready_after", in_ready, 1'b1);
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the LEGv8 datapath. It replaces the fixed-width extenders with one block. The block takes a 32-bit instruction plus a format code from control, then extracts the immediate field. It sign- or zero-extends the field to DATA_W and applies the format's shift. The block sits between the instruction register and the ALU B-mux, uses valid/ready handshakes on both sides, and supports a flush from branch resolution.

## Interface
- DATA_W, 64, output width; legal range 32..64.
- TAG_W, 4, width of sideband tag carried alongside each instruction (e.g. ROB/slot id).
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all valid state.
- flush  input  1  synchronous; discards every in-flight entry.
- in_valid  input  1  instr/fmt/tag present.
- in_ready  output  1  block accepts this cycle.
- instr  input  32  raw instruction word.
- fmt  input  3  format code: 0 NONE, 1 I, 2 D, 3 B, 4 CB, 5 IW, 6–7 reserved.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- imm  output  DATA_W  extended, shifted immediate.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  reserved fmt, or IW shift exceeds DATA_W.

## Operation
- Field extraction and extension rules:
  - I: instr[21:10], zero-extended.
  - D: instr[20:12], sign-extended.
  - B: instr[25:0], sign-extended, then <<2.
  - CB: instr[23:5], sign-extended, then <<2.
  - IW: instr[20:5] zero-extended, then << (16·instr[22:21]).
  - NONE: imm = 0, err = 0.
- The shift is applied after extension, at DATA_W width. Bits shifted past the MSB are dropped; no saturation.
- IW with 16·hw + 16 > DATA_W: imm = 0, out_err = 1.
- Reserved fmt: imm = 0, out_err = 1. The entry still flows through the pipeline and still occupies a slot.
- Stage 1 (S1) registers the extracted raw field, the shift amount, the extension mode, the error flag and the tag.
- Stage 2 (S2) registers the extended and shifted result. imm, out_tag and out_err are driven directly from S2 registers.
- Each stage holds one valid bit. A stage advances when it is empty or when its downstream stage accepts.
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- While out_valid=1 and out_ready=0, imm, out_tag and out_err hold stable.
- Flush clears s1_valid and s2_valid on the next edge. An input presented in the flush cycle is dropped, even if in_ready=1. Flush overrides all simultaneous transfers.
- Reset mid-operation: all valids drop immediately, in-flight data is lost, and nothing is replayed.

## Timing
- Latency: 2 cycles from input transfer to out_valid, with out_ready held high.
- Throughput: 1 result per cycle sustained, with no bubbles when out_ready=1.
- Reset values:
  - out_valid = 0, imm = 0, out_tag = 0, out_err = 0.
  - in_ready = 1 once reset deasserts.
- Full condition: both stages valid and out_ready=0 gives in_ready=0 in the same cycle (combinational from out_ready). There is no third entry and no skid buffer.
- Empty pipeline: in_ready=1 and out_valid=0.
- Back-to-back input transfer and output transfer in the same cycle are legal.
- Outputs never change without an output transfer, flush or reset.

## Structure
- Package imm_gen_pkg holds:
  - fmt_e enum (NONE, I, D, B, CB, IW, RSV6, RSV7).
  - localparams for field LSB/MSB positions of each format.
  - IW hw field position.
  - Branch shift constant (2).
- Sub-module imm_gen_stage: a one-entry valid/ready pipeline register, parametrised on payload width.
  - Instantiated twice (S1, S2).
  - Owns its valid bit, flush, reset and advance logic.
- Extraction and extension logic is combinational in the top, between the stages.

## Test plan
- Reset then single B entry: fmt=3, instr[25:0]=26'h3FFFFFF, tag=5 -> two cycles later imm=64'hFFFF_FFFF_FFFF_FFFC, out_tag=5, err=0.
- Stream of four entries, out_ready=1, one per cycle: CB instr[23:5]=19'h00001; D instr[20:12]=9'h100; I instr[21:10]=12'hFFF; IW instr[20:5]=16'hBEEF with hw=2 -> imm = 4, 64'hFFFF_FFFF_FFFF_FF00, 64'h0000_0000_0000_0FFF, 64'h0000_BEEF_0000_0000 on consecutive cycles, tags in order.
- Backpressure: three inputs with out_ready=0 -> in_ready drops after two accepted, the third is held by the producer, outputs are stable. Release out_ready -> all three emerge in order, with no loss or duplication.
- Flush with both stages full and in_valid=1 -> next cycle out_valid=0 and the flushed entries never appear. An entry sent the following cycle emerges normally after 2 cycles.
- Errors: fmt=6 -> imm=0, err=1. IW hw=3 with DATA_W=32 -> imm=0, err=1. fmt=0 -> imm=0, err=0.
- Async reset asserted mid-stream, between clock edges -> out_valid and in-flight state clear immediately. After release, in_ready=1 and no stale result appears.
